// File: rtl/alu_pkg.sv
// Shared definitions for the ALU write-back stage: opcodes, flag bit
// positions and the packed entry carried through the output/skid buffer.
package alu_pkg;

  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_RD_W   = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [2:0]              opcode;
    logic [ENTRY_DATA_W:0]   result;
    logic                    op1_msb;
    logic                    op2_msb;
    logic [ENTRY_RD_W-1:0]   rd;
    logic                    set_flags;
  } entry_t;

  // NOP and the reserved opcode are consumed without producing a write-back.
  function automatic logic is_dropped(input logic [2:0] opcode);
    return (opcode == OP_NOP) || (opcode == OP_RSV);
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational next-flags computation for one retiring entry.
// V is the true two's-complement overflow derived from operand and result signs.
module alu_flag_calc
  import alu_pkg::*;
(
  input  entry_t     entry,
  input  logic [3:0] flags_cur,
  output logic [3:0] flags_next
);

  logic [ENTRY_DATA_W-1:0] data;
  logic                    data_msb;
  logic                    unused_fields;

  assign data          = entry.result[ENTRY_DATA_W-1:0];
  assign data_msb      = data[ENTRY_DATA_W-1];
  assign unused_fields = ^{entry.rd, entry.set_flags};

  always_comb begin
    flags_next         = flags_cur;
    flags_next[FLAG_N] = data_msb;
    flags_next[FLAG_Z] = (data == '0);
    case (entry.opcode)
      OP_ADD: begin
        flags_next[FLAG_C] = entry.result[ENTRY_DATA_W];
        flags_next[FLAG_V] = (entry.op1_msb == entry.op2_msb) && (data_msb != entry.op1_msb);
      end
      OP_SUB: begin
        flags_next[FLAG_C] = entry.result[ENTRY_DATA_W];
        flags_next[FLAG_V] = (entry.op1_msb != entry.op2_msb) && (data_msb != entry.op1_msb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: output register plus one skid entry, in-order retire,
// architectural N/Z/C/V flags built only when ALU_WB_FLAGS_EN is defined.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = ENTRY_DATA_W,
  parameter int RD_W   = ENTRY_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [DATA_W:0]   in_result,
  input  logic              in_op1_msb,
  input  logic              in_op2_msb,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_set_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic [3:0]        flags
);

  entry_t in_entry;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid;
  logic   skid_valid;
  logic   in_ready_q;
  logic   keep;
  logic   retire;
  logic   skid_fill;
  logic   skid_drain;

  always_comb begin
    in_entry           = '0;
    in_entry.opcode    = in_opcode;
    in_entry.result    = in_result;
    in_entry.op1_msb   = in_op1_msb;
    in_entry.op2_msb   = in_op2_msb;
    in_entry.rd        = in_rd;
    in_entry.set_flags = in_set_flags;
  end

  assign keep       = in_valid && in_ready_q && !is_dropped(in_opcode);
  assign retire     = out_valid && wb_ready;
  assign skid_fill  = keep && out_valid && !retire;
  assign skid_drain = retire && skid_valid;

  // The skid only drains while in_ready is low, so a drain never races an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      if (skid_drain) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end else if (keep && (!out_valid || retire)) begin
        out_q     <= in_entry;
        out_valid <= 1'b1;
      end else if (keep) begin
        skid_q     <= in_entry;
        skid_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      in_ready_q <= !(skid_fill || (skid_valid && !skid_drain));
    end
  end

  assign in_ready = in_ready_q;
  assign wb_valid = out_valid;
  assign wb_data  = out_q.result[DATA_W-1:0];
  assign wb_rd    = out_q.rd;

`ifdef ALU_WB_FLAGS_EN
  logic [3:0] flags_q;
  logic [3:0] flags_next;

  alu_flag_calc u_flag_calc (
    .entry      (out_q),
    .flags_cur  (flags_q),
    .flags_next (flags_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (retire && out_q.set_flags) begin
      flags_q <= flags_next;
    end
  end

  assign flags = flags_q;
`else
  logic unused_flag_fields;

  assign unused_flag_fields = ^{out_q.result[DATA_W], out_q.op1_msb, out_q.op2_msb,
                                out_q.set_flags, out_q.opcode};
  assign flags = 4'b0000;
`endif

endmodule
